memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the pipelined CPU, sitting between execute and `write_back`. Accepts one instruction at a time from the EX/MEM boundary and performs the data-memory access for LW/SW using a request/acknowledge handshake with wait-state and timeout support. Registers the MEM/WB values (`instruction_out`, `data_output`, `mem_data_output`) that feed the `write_back` mux. Non-memory instructions pass through at one per cycle.

## Interface
- `ADDR_WIDTH`, 10: word-address width toward data memory.
- `TIMEOUT`, 15: maximum wait cycles for `mem_ack` before aborting an access (1..255).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: stage accepts this cycle; transfer when `in_valid && in_ready` at the clock edge.
- `instruction_in` in 32: instruction; opcode is `[31:27]`.
- `alu_result_in` in 32: byte address for LW/SW, result value otherwise.
- `store_data_in` in 32: SW write data.
- `mem_req` out 1: data-memory request, held until ack or timeout.
- `mem_we` out 1: 1 = write (SW), 0 = read (LW); valid while `mem_req`.
- `mem_addr` out ADDR_WIDTH: word address = `alu_result_in[ADDR_WIDTH+1:2]`.
- `mem_wdata` out 32: store data.
- `mem_ack` in 1: memory completes the access this cycle.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `out_valid` out 1: one-cycle pulse, MEM/WB registers hold a retired instruction.
- `instruction_out` out 32: retired instruction, to `write_back.instruction`.
- `data_output` out 32: ALU result, to `write_back.data_input`.
- `mem_data_output` out 32: load data, to `write_back.mem_data_input`.
- `mem_timeout` out 1: one-cycle pulse when an access is aborted.

## Operation
- Opcode decode: 0 = LW, 1 = SW (memory); 2..31 = non-memory pass-through.
- States: IDLE, ACCESS.
- IDLE: `in_ready`=1 (0 while `reset` is high). On transfer:
  - Non-memory: latch `instruction_out`←instruction, `data_output`←`alu_result_in`, `mem_data_output`←0; pulse `out_valid`; stay in IDLE.
  - LW/SW: latch instruction, `data_output`←`alu_result_in`, address, write data, `mem_we`; set `mem_req`; clear wait counter; go to ACCESS.
- ACCESS: `in_ready`=0; `mem_req`, `mem_addr`, `mem_wdata`, `mem_we` held stable.
  - `mem_ack`=1: drop `mem_req`; `mem_data_output`←`mem_rdata` for LW, 0 for SW; pulse `out_valid`; go to IDLE.
  - No ack: increment 8-bit wait counter. When counter reaches TIMEOUT-1 without ack, drop `mem_req`, `mem_data_output`←0, pulse `out_valid` and `mem_timeout`, go to IDLE.
- `mem_ack` in IDLE is ignored. Address bits `[1:0]` are discarded; no misalignment fault.
- The MEM/WB registers hold their values between pulses; `write_back` consumes them combinationally.
- Reset clears state to IDLE, and clears `mem_req`, `mem_we`, `out_valid`, `mem_timeout`, the counter, `mem_addr`, `mem_wdata`, `instruction_out`, `data_output`, and `mem_data_output` to 0.

## Timing
- Non-memory: accepted at edge N; `out_valid` high during cycle N→N+1. Throughput is 1 instruction per cycle.
- Memory: accepted at edge N; `mem_req` high from N. If `mem_ack` is sampled at edge M (M ≥ N+1), `mem_req` is low and `out_valid` high during M→M+1, and `in_ready` is 1 in that same cycle. Minimum LW/SW latency is 2 edges.
- Timeout: with no ack, `mem_req` stays high for exactly TIMEOUT cycles, followed by a cycle with `out_valid`=`mem_timeout`=1.
- `mem_ack` arriving in the same cycle as the timeout expiry is a completion, not a timeout.
- Reset mid-ACCESS: at the reset edge, `mem_req` and `out_valid` drop, the in-flight instruction is discarded with no `out_valid`, and the state returns to IDLE. `in_ready` returns in the first cycle after `reset` is deasserted.
- `in_valid` held high during ACCESS is not accepted; the upstream stage holds its inputs.

## Test plan
- Reset, then three back-to-back ADD (opcode 2), `alu_result_in`=5,6,7 -> three consecutive `out_valid` pulses, `data_output`=5,6,7, `mem_data_output`=0, `mem_req` never high.
- LW, `alu_result_in`=0x40; memory acks 3 cycles later with `mem_rdata`=0xDEADBEEF -> `mem_addr`=0x10, `mem_we`=0, `mem_req` high for 3 cycles, then `out_valid` with `mem_data_output`=0xDEADBEEF, `instruction_out[31:27]`=0.
- SW, addr 0x8, `store_data_in`=0x1234, immediate ack -> `mem_we`=1, `mem_wdata`=0x1234, `mem_addr`=2, `out_valid` on the next cycle, `mem_data_output`=0.
- LW with no ack, TIMEOUT=15 -> `mem_req` high for exactly 15 cycles, then `out_valid`=`mem_timeout`=1 with `mem_data_output`=0, then a new instruction is accepted.
- LW followed by a held ADD -> the ADD is accepted only in the cycle of the LW's `out_valid`, and retires one cycle later.
- `reset` asserted in the 2nd wait cycle of an LW -> `mem_req`=0 and `out_valid`=0 after the edge; a late `mem_ack` is ignored; no retirement occurs for that LW.

Source files
------------

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Memory-access stage of the pipelined CPU, between execute and write_back.
// Takes one instruction at a time from the EX/MEM boundary. LW and SW run a
// request/acknowledge transaction against data memory; that transaction has
// wait states and a timeout. Every other opcode passes straight through at
// one instruction per cycle. The MEM/WB registers (instruction_out,
// data_output, mem_data_output) hold their values between retirements, and
// write_back reads them combinationally.
//
// Parameters
//   ADDR_WIDTH  word-address width toward data memory
//   TIMEOUT     cycles mem_req may stay high without mem_ack (1..255)
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; transfer when both are high
//   instruction_in      instruction word, opcode in [31:27]
//   alu_result_in       byte address for LW/SW, result value otherwise
//   store_data_in       SW write data
//   mem_req/mem_we      memory request and direction (1 = write)
//   mem_addr/mem_wdata  word address and store data, stable while mem_req
//   mem_ack/mem_rdata   memory completion and read data
//   out_valid           one-cycle retirement pulse
//   instruction_out     retired instruction
//   data_output         ALU result of the retired instruction
//   mem_data_output     load data (0 for everything except a completed LW)
//   mem_timeout         one-cycle pulse when an access is aborted
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction_in,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           store_data_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  out_valid,
  output logic [31:0]           instruction_out,
  output logic [31:0]           data_output,
  output logic [31:0]           mem_data_output,
  output logic                  mem_timeout
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [4:0] OP_LW = 5'd0;
  localparam logic [4:0] OP_SW = 5'd1;

  // Last wait-counter value before the access is abandoned. The counter
  // starts at 0 in the first request cycle, so the values 0..TIMEOUT-1 give
  // exactly TIMEOUT cycles with mem_req high.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             instr_q, instr_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             mdata_q, mdata_d;
  logic                    out_valid_q, out_valid_d;
  logic                    timeout_q, timeout_d;

  logic [4:0]              opcode;
  logic                    is_mem;
  logic                    is_store;
  logic                    accept;
  logic                    expire;

  assign opcode   = instruction_in[31:27];
  assign is_store = (opcode == OP_SW);
  assign is_mem   = (opcode == OP_LW) || is_store;

  // in_ready is held low during reset so that no transfer is seen at the
  // reset edge.
  assign in_ready = (state_q == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // A timeout only applies when no ack arrives. An ack in the expiry cycle
  // counts as a normal completion.
  assign expire   = (state_q == S_ACCESS) && !mem_ack && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      instr_q     <= '0;
      data_q      <= '0;
      mdata_q     <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      instr_q     <= instr_d;
      data_q      <= data_d;
      mdata_q     <= mdata_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && is_mem) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack || expire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic: the MEM/WB and memory-interface registers hold
  // their values unless this cycle loads them.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    instr_d     = instr_q;
    data_d      = data_q;
    mdata_d     = mdata_q;
    out_valid_d = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          instr_d = instruction_in;
          data_d  = alu_result_in;
          if (is_mem) begin
            // Byte-address bits [1:0] are dropped; misalignment is not checked.
            addr_d  = alu_result_in[ADDR_WIDTH+1:2];
            wdata_d = store_data_in;
            we_d    = is_store;
            req_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            mdata_d     = '0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          req_d       = 1'b0;
          mdata_d     = we_q ? 32'd0 : mem_rdata;
          out_valid_d = 1'b1;
        end else if (expire) begin
          req_d       = 1'b0;
          mdata_d     = '0;
          out_valid_d = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign out_valid       = out_valid_q;
  assign instruction_out = instr_q;
  assign data_output     = data_q;
  assign mem_data_output = mdata_q;
  assign mem_timeout     = timeout_q;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Scoreboard bench for memory_stage. The stimulus process drives directed
// vectors and pushes each expected retirement into a queue. The monitor
// process pops one entry and compares it whenever out_valid is high.
// Memory-interface values and request durations are checked inline.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int ADDR_WIDTH = 10;
  localparam int TIMEOUT    = 15;

  logic                  clock;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instruction_in;
  logic [31:0]           alu_result_in;
  logic [31:0]           store_data_in;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;
  logic                  out_valid;
  logic [31:0]           instruction_out;
  logic [31:0]           data_output;
  logic [31:0]           mem_data_output;
  logic                  mem_timeout;

  memory_stage #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction_in  (instruction_in),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .out_valid       (out_valid),
    .instruction_out (instruction_out),
    .data_output     (data_output),
    .mem_data_output (mem_data_output),
    .mem_timeout     (mem_timeout)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] mdata;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   req_cycles = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (mem_req) req_cycles++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", instruction_out, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instruction_out", instruction_out, e.instr);
        chk("data_output", data_output, e.data);
        chk("mem_data_output", mem_data_output, e.mdata);
        chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [26:0] rest);
    return {op, rest};
  endfunction

  task automatic push(input logic [31:0] i, input logic [31:0] d, input logic [31:0] m,
                      input logic t);
    exp_t e;
    e.instr = i;
    e.data  = d;
    e.mdata = m;
    e.to    = t;
    sb.push_back(e);
  endtask

  initial begin
    logic [31:0] lw_i;
    reset          = 1'b1;
    in_valid       = 1'b0;
    instruction_in = '0;
    alu_result_in  = '0;
    store_data_in  = '0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    step();
    step();
    step();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instruction_out", instruction_out, 32'd0);
    chk("rst_data_output", data_output, 32'd0);
    chk("rst_mem_data_output", mem_data_output, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Three back-to-back ADDs
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid       = 1'b1;
      instruction_in = mk_instr(5'd2, 27'(i + 1));
      alu_result_in  = 32'(5 + i);
      push(instruction_in, alu_result_in, 32'd0, 1'b0);
      chk("add_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("add_no_req", 32'(req_cycles), 32'd0);

    // LW, ack three cycles after acceptance
    req_cycles     = 0;
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd0, 27'h1);
    alu_result_in  = 32'h40;
    store_data_in  = 32'h55;
    push(instruction_in, 32'h40, 32'hDEAD_BEEF, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lw_mem_req", 32'(mem_req), 32'd1);
    chk("lw_mem_addr", 32'(mem_addr), 32'h10);
    chk("lw_mem_we", 32'(mem_we), 32'd0);
    chk("lw_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    chk("lw_ready_with_valid", 32'(in_ready), 32'd1);
    step();
    chk("lw_req_cycles", 32'(req_cycles), 32'd3);

    // SW with immediate ack; read data must not reach mem_data_output
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd1, 27'h2);
    alu_result_in  = 32'h8;
    store_data_in  = 32'h1234;
    push(instruction_in, 32'h8, 32'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_wdata", mem_wdata, 32'h1234);
    chk("sw_mem_addr", 32'(mem_addr), 32'd2);
    chk("sw_mem_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("sw_out_valid", 32'(out_valid), 32'd1);
    step();

    // LW with no ack: timeout
    req_cycles     = 0;
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd0, 27'h3);
    alu_result_in  = 32'h100;
    push(instruction_in, 32'h100, 32'd0, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_out_valid", 32'(out_valid), 32'd1);
    chk("to_in_ready", 32'(in_ready), 32'd1);
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd3, 27'h4);
    alu_result_in  = 32'h77;
    push(instruction_in, 32'h77, 32'd0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("to_next_accepted", 32'(out_valid), 32'd1);
    step();
    chk("to_req_cycles", 32'(req_cycles), 32'(TIMEOUT));

    // LW followed by an ADD that is held during the access
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd0, 27'h5);
    alu_result_in  = 32'h20;
    push(instruction_in, 32'h20, 32'hCAFE_F00D, 1'b0);
    step();
    instruction_in = mk_instr(5'd2, 27'h6);
    alu_result_in  = 32'h99;
    push(instruction_in, 32'h99, 32'd0, 1'b0);
    chk("held_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("held_still_blocked", 32'(in_ready), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("held_ready_at_retire", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("held_add_retires", data_output, 32'h99);
    step();

    // Reset in the second wait cycle of an LW, then a late ack
    in_valid       = 1'b1;
    instruction_in = mk_instr(5'd0, 27'h7);
    alu_result_in  = 32'h30;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    #1;
    chk("mid_rst_ready_back", 32'(in_ready), 32'd1);
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("late_ack_out_valid", 32'(out_valid), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_mdata", mem_data_output, 32'd0);
    step();
    step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
